// File: rtl/angle_range_reducer.sv
// angle_range_reducer
//   Pre-stage for the fixed-point cosine Taylor stage. It takes a signed Q.10
//   angle and reduces |angle| modulo 2*pi with a fixed-latency shift-subtract
//   loop. It then folds the remainder into [0, pi/2] and reports whether the
//   downstream cosine result must be negated.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   start          in   conversion request, sampled only while idle
//   angle_in       in   W-bit signed Q.10 angle (two's complement)
//   ready_out      out  result valid (level), cleared when the next start is accepted
//   reduced_angle  out  folded angle in [0, HALF_PI], unsigned in W bits
//   negate_out     out  1 = downstream cosine result must be negated
//   quadrant       out  quadrant (0..3) of the reduced angle
module angle_range_reducer #(
  parameter int W             = 24,
  parameter int TWO_PI        = 6434,
  parameter int PI            = 3217,
  parameter int HALF_PI       = 1608,
  parameter int THREE_HALF_PI = 4825
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] angle_in,
  output logic         ready_out,
  output logic [W-1:0] reduced_angle,
  output logic         negate_out,
  output logic [1:0]   quadrant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    FOLD   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Magnitude needs one extra bit so that |-2^(W-1)| = 2^(W-1) is representable.
  localparam int MW = W + 1;

  localparam logic [MW-1:0] TWO_PI_M        = MW'(TWO_PI);
  localparam logic [MW-1:0] PI_M            = MW'(PI);
  localparam logic [MW-1:0] HALF_PI_M       = MW'(HALF_PI);
  localparam logic [MW-1:0] THREE_HALF_PI_M = MW'(THREE_HALF_PI);

  state_t          state_r;
  logic [MW-1:0]   mag_r;
  logic [3:0]      k_r;

  logic [MW-1:0]   trial_s;
  logic [MW-1:0]   diff_s;
  logic            ge_s;
  logic [W-1:0]    fold_angle_s;
  logic            fold_neg_s;
  logic [1:0]      fold_quad_s;

  // Absolute value of a signed W-bit angle, widened to W+1 bits.
  function automatic logic [MW-1:0] abs_ext(input logic [W-1:0] a);
    logic [MW-1:0] ext;
    ext = {a[W-1], a};
    if (a[W-1]) begin
      abs_ext = ~ext + {{(MW-1){1'b0}}, 1'b1};
    end else begin
      abs_ext = ext;
    end
  endfunction

  // One reduction step: compare and subtract TWO_PI scaled by 2^k.
  always_comb begin
    trial_s = TWO_PI_M << k_r;
    ge_s    = (mag_r >= trial_s);
    diff_s  = mag_r - trial_s;
  end

  // Fold the remainder r in [0, TWO_PI) into [0, HALF_PI]; bounds are inclusive.
  always_comb begin
    fold_angle_s = {W{1'b0}};
    fold_neg_s   = 1'b0;
    fold_quad_s  = 2'd0;
    if (mag_r <= HALF_PI_M) begin
      fold_angle_s = W'(mag_r);
      fold_neg_s   = 1'b0;
      fold_quad_s  = 2'd0;
    end else if (mag_r <= PI_M) begin
      fold_angle_s = W'(PI_M - mag_r);
      fold_neg_s   = 1'b1;
      fold_quad_s  = 2'd1;
    end else if (mag_r <= THREE_HALF_PI_M) begin
      fold_angle_s = W'(mag_r - PI_M);
      fold_neg_s   = 1'b1;
      fold_quad_s  = 2'd2;
    end else begin
      fold_angle_s = W'(TWO_PI_M - mag_r);
      fold_neg_s   = 1'b0;
      fold_quad_s  = 2'd3;
    end
  end

  // Control FSM, reduction datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      mag_r         <= {MW{1'b0}};
      k_r           <= 4'd0;
      ready_out     <= 1'b0;
      reduced_angle <= {W{1'b0}};
      negate_out    <= 1'b0;
      quadrant      <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mag_r     <= abs_ext(angle_in);
            k_r       <= 4'd10;
            ready_out <= 1'b0;
            state_r   <= REDUCE;
          end else begin
            state_r   <= IDLE;
          end
        end
        REDUCE: begin
          if (ge_s) begin
            mag_r <= diff_s;
          end else begin
            mag_r <= mag_r;
          end
          // k=0 is the last step; k stays 0 until the next accepted start.
          if (k_r == 4'd0) begin
            state_r <= FOLD;
          end else begin
            k_r     <= k_r - 4'd1;
          end
        end
        FOLD: begin
          reduced_angle <= fold_angle_s;
          negate_out    <= fold_neg_s;
          quadrant      <= fold_quad_s;
          ready_out     <= 1'b1;
          state_r       <= DONE;
        end
        DONE: begin
          // Wait for start to drop so one request yields exactly one conversion.
          if (!start) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_angle_range_reducer.sv
module tb_angle_range_reducer;
  localparam int W = 24;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] angle_in;
  logic         ready_out;
  logic [W-1:0] reduced_angle;
  logic         negate_out;
  logic [1:0]   quadrant;

  int total_cnt = 0;
  int pass_cnt  = 0;

  angle_range_reducer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .angle_in     (angle_in),
    .ready_out    (ready_out),
    .reduced_angle(reduced_angle),
    .negate_out   (negate_out),
    .quadrant     (quadrant)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] angle;
    int           exp_angle;
    int           exp_neg;
    int           exp_q;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input longint got, input longint exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference: plain modulo arithmetic on |angle|, then fold by quadrant.
  task automatic model(input logic [W-1:0] a, output int ea, output int en, output int eq);
    longint v;
    longint r;
    v = longint'($signed(a));
    if (v < 0) v = -v;
    r = v % 6434;
    if (r <= 1608)      begin ea = int'(r);        en = 0; eq = 0; end
    else if (r <= 3217) begin ea = int'(3217 - r); en = 1; eq = 1; end
    else if (r <= 4825) begin ea = int'(r - 3217); en = 1; eq = 2; end
    else                begin ea = int'(6434 - r); en = 0; eq = 3; end
  endtask

  // Wait (bounded) for ready_out after the accepting edge; returns edge count or -1.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (ready_out) begin
        lat = c;
        break;
      end
    end
  endtask

  // One full handshaked conversion, checking latency and results.
  task automatic run_check(input string name, input logic [W-1:0] a,
                           input int ea, input int en, input int eq);
    int lat;
    @(negedge clock);
    angle_in = a;
    start    = 1'b1;
    @(posedge clock); #1;
    check({name, "_ready_clear"}, ready_out, 0);
    wait_ready(lat);
    check({name, "_latency"}, lat, 12);
    check({name, "_angle"}, reduced_angle, ea);
    check({name, "_negate"}, negate_out, en);
    check({name, "_quadrant"}, quadrant, eq);
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ea, en, eq, lat;
    logic [W-1:0] ra;

    reset    = 1'b1;
    start    = 1'b0;
    angle_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", ready_out, 0);
    check("rst_angle", reduced_angle, 0);
    check("rst_negate", negate_out, 0);
    check("rst_quadrant", quadrant, 0);
    @(negedge clock);
    reset = 1'b0;

    vecs.push_back('{24'd0,        0,    0, 0});
    vecs.push_back('{24'd1024,     1024, 0, 0});
    vecs.push_back('{24'd2048,     1169, 1, 1});
    vecs.push_back('{24'hFFF800,   1169, 1, 1});   // -2048
    vecs.push_back('{24'd4000,     783,  1, 2});
    vecs.push_back('{24'd6000,     434,  0, 3});
    vecs.push_back('{24'd7000,     566,  0, 0});
    vecs.push_back('{24'd1608,     1608, 0, 0});
    vecs.push_back('{24'd3217,     0,    1, 1});
    vecs.push_back('{24'd4825,     1608, 1, 2});
    vecs.push_back('{24'd6434,     0,    0, 0});
    vecs.push_back('{24'h800000,   1328, 0, 3});   // most negative
    vecs.push_back('{24'h7FFFFF,   1329, 0, 3});   // most positive

    foreach (vecs[i]) begin
      run_check($sformatf("vec%0d", i), vecs[i].angle,
                vecs[i].exp_angle, vecs[i].exp_neg, vecs[i].exp_q);
    end

    // Random angles, both full-range and small magnitudes near the fold bounds.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) ra = W'($urandom);
      else            ra = W'($urandom_range(0, 13000)) - W'(6500);
      model(ra, ea, en, eq);
      run_check($sformatf("rnd%0d", i), ra, ea, en, eq);
    end

    // Reset during REDUCE (k=5 step) aborts; nothing completes afterwards.
    run_check("pre_abort", 24'd2048, 1169, 1, 1);
    @(negedge clock);
    angle_in = 24'd7000;
    start    = 1'b1;
    @(posedge clock);              // accepting edge
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(posedge clock);   // steps k=10..6
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_ready", ready_out, 0);
    check("abort_angle", reduced_angle, 0);
    check("abort_negate", negate_out, 0);
    check("abort_quadrant", quadrant, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    check("abort_no_ready", ready_out, 0);
    check("abort_hold_angle", reduced_angle, 0);

    // start held high with angle_in changed mid-conversion.
    @(negedge clock);
    angle_in = 24'd1024;
    start    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    angle_in = 24'd3217;
    wait_ready(lat);
    check("hold_latency", lat, 12);
    check("hold_angle", reduced_angle, 1024);
    check("hold_negate", negate_out, 0);
    check("hold_quadrant", quadrant, 0);
    repeat (20) @(posedge clock);
    #1;
    check("hold_no_restart_ready", ready_out, 1);
    check("hold_no_restart_angle", reduced_angle, 1024);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock); #1;
    check("idle_ready_level", ready_out, 1);
    @(posedge clock); #1;
    check("idle_angle_hold", reduced_angle, 1024);
    run_check("after_hold", 24'd3217, 0, 1, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
